// File: rtl/seq_accum_alu.sv
// ============================================================================
// Module   : seq_accum_alu
// Brief    : Sequential accumulator ALU. A start request latches the operands,
//            and one operation runs per request. The result, the status flags
//            and the accumulator update are reported with a one-cycle done
//            pulse. The iterative restoring divider is included only when
//            SEQ_ACCUM_ALU_DIV_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_accum_alu #(
  parameter int WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [3:0]           opcode,
  input  logic                 use_acc,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic [WIDTH-1:0]     acc,
  output logic                 err,
  output logic                 zero,
  output logic                 carry
);

  localparam logic [3:0] c_op_clr  = 4'd0;
  localparam logic [3:0] c_op_not  = 4'd1;
  localparam logic [3:0] c_op_shr  = 4'd2;
  localparam logic [3:0] c_op_shl  = 4'd3;
  localparam logic [3:0] c_op_add  = 4'd4;
  localparam logic [3:0] c_op_sub  = 4'd5;
  localparam logic [3:0] c_op_mul  = 4'd6;
  localparam logic [3:0] c_op_and  = 4'd8;
  localparam logic [3:0] c_op_or   = 4'd9;
  localparam logic [3:0] c_op_xor  = 4'd10;
  localparam logic [3:0] c_op_load = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
`ifdef SEQ_ACCUM_ALU_DIV_EN
    S_DIV  = 2'd2,
`endif
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_x;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_result;
  logic [WIDTH-1:0]   r_acc;
  logic               r_err;
  logic               r_zero;
  logic               r_carry;

  logic               w_accept;
  logic [WIDTH-1:0]   w_x_in;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_x_in   = use_acc ? r_acc : a;

`ifdef SEQ_ACCUM_ALU_DIV_EN
  localparam logic [3:0] c_op_div = 4'd7;
  localparam int         CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] c_cnt_last = CW'(WIDTH);

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [CW-1:0]    r_cnt;
  logic             w_div_go;
  logic [WIDTH:0]   w_shift;
  logic             w_fits;
  logic [WIDTH-1:0] w_diff;

  assign w_div_go = (opcode == c_op_div) && (b != '0);

  // Partial remainder never exceeds the divisor, so the difference fits WIDTH bits.
  assign w_shift  = {r_rem, r_quo[WIDTH-1]};
  assign w_fits   = (w_shift >= {1'b0, r_b});
  assign w_diff   = w_shift[WIDTH-1:0] - r_b;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rem <= '0;
      r_quo <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_rem <= '0;
      r_quo <= w_x_in;
      r_cnt <= '0;
    end else if ((r_state == S_DIV) && (r_cnt != c_cnt_last)) begin
      r_rem <= w_fits ? w_diff : w_shift[WIDTH-1:0];
      r_quo <= {r_quo[WIDTH-2:0], w_fits};
      r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
    end
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
`ifdef SEQ_ACCUM_ALU_DIV_EN
          w_next = w_div_go ? S_DIV : S_EXEC;
`else
          w_next = S_EXEC;
`endif
        end
      end
      S_EXEC: w_next = S_DONE;
`ifdef SEQ_ACCUM_ALU_DIV_EN
      S_DIV: begin
        if (r_cnt == c_cnt_last) begin
          w_next = S_DONE;
        end
      end
`endif
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_low;
  logic [2*WIDTH-1:0] w_alu;
  logic               w_alu_err;
  logic               w_alu_cy;

  assign w_sum  = {1'b0, r_x} + {1'b0, r_b};
  assign w_prod = {{WIDTH{1'b0}}, r_x} * {{WIDTH{1'b0}}, r_b};

  // A divide reaching EXEC always has a zero divisor (or no divider), so it is an error.
  always_comb begin
    w_low     = '0;
    w_alu_err = 1'b0;
    w_alu_cy  = 1'b0;
    case (r_op)
      c_op_clr:  w_low = '0;
      c_op_not:  w_low = ~r_x;
      c_op_shr:  w_low = {1'b0, r_x[WIDTH-1:1]};
      c_op_shl:  w_low = {r_x[WIDTH-2:0], 1'b0};
      c_op_add: begin
        w_low    = w_sum[WIDTH-1:0];
        w_alu_cy = w_sum[WIDTH];
      end
      c_op_sub: begin
        w_low    = r_x - r_b;
        w_alu_cy = (r_x < r_b);
      end
      c_op_mul:  w_low = '0;
      c_op_and:  w_low = r_x & r_b;
      c_op_or:   w_low = r_x | r_b;
      c_op_xor:  w_low = r_x ^ r_b;
      c_op_load: w_low = r_x;
      default:   w_alu_err = 1'b1;
    endcase
    w_alu = (r_op == c_op_mul) ? w_prod : {{WIDTH{1'b0}}, w_low};
  end

  logic               w_commit;
  logic [2*WIDTH-1:0] w_res;
  logic               w_res_err;
  logic               w_res_cy;

  always_comb begin
    w_commit  = (r_state == S_EXEC);
    w_res     = w_alu;
    w_res_err = w_alu_err;
    w_res_cy  = w_alu_cy;
`ifdef SEQ_ACCUM_ALU_DIV_EN
    if ((r_state == S_DIV) && (r_cnt == c_cnt_last)) begin
      w_commit  = 1'b1;
      w_res     = {r_rem, r_quo};
      w_res_err = 1'b0;
      w_res_cy  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_op     <= '0;
      r_x      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_acc    <= '0;
      r_err    <= 1'b0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op <= opcode;
        r_x  <= w_x_in;
        r_b  <= b;
      end
      // Results land on the edge entering DONE so they are valid with the done pulse.
      if (w_commit) begin
        r_result <= w_res;
        r_err    <= w_res_err;
        r_zero   <= (w_res == '0);
        r_carry  <= w_res_cy;
        if (!w_res_err) begin
          r_acc <= w_res[WIDTH-1:0];
        end
      end
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign acc    = r_acc;
  assign err    = r_err;
  assign zero   = r_zero;
  assign carry  = r_carry;

endmodule

`default_nettype wire

// File: tb/tb_seq_accum_alu.sv
// ============================================================================
// Module   : tb_seq_accum_alu
// Brief    : Self-checking bench for seq_accum_alu (WIDTH=16 and WIDTH=8
//            instances) against an arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_accum_alu;

`ifdef SEQ_ACCUM_ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        start16, ua16, busy16, done16, err16, zero16, carry16;
  logic [3:0]  opc16;
  logic [15:0] a16, b16, acc16;
  logic [31:0] res16;

  logic        start8, ua8, busy8, done8, err8, zero8, carry8;
  logic [3:0]  opc8;
  logic [7:0]  a8, b8, acc8;
  logic [15:0] res8;

  seq_accum_alu #(.WIDTH(16)) u_dut16 (
    .clock(clock), .reset(reset), .start(start16), .opcode(opc16),
    .use_acc(ua16), .a(a16), .b(b16), .busy(busy16), .done(done16),
    .result(res16), .acc(acc16), .err(err16), .zero(zero16), .carry(carry16)
  );

  seq_accum_alu #(.WIDTH(8)) u_dut8 (
    .clock(clock), .reset(reset), .start(start8), .opcode(opc8),
    .use_acc(ua8), .a(a8), .b(b8), .busy(busy8), .done(done8),
    .result(res8), .acc(acc8), .err(err8), .zero(zero8), .carry(carry8)
  );

  int tests = 0;
  int fails = 0;
  int sel   = 0;
  logic [31:0] m_acc [2];

  logic [63:0] o_res;
  logic [31:0] o_acc;
  logic        o_busy, o_done, o_err, o_zero, o_carry;

  always_comb begin
    if (sel == 1) begin
      o_res = {48'd0, res8};  o_acc = {24'd0, acc8};
      o_busy = busy8; o_done = done8; o_err = err8; o_zero = zero8; o_carry = carry8;
    end else begin
      o_res = {32'd0, res16}; o_acc = {16'd0, acc16};
      o_busy = busy16; o_done = done16; o_err = err16; o_zero = zero16; o_carry = carry16;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on the operand values, masked to the width.
  function automatic void model(input int w, input logic [3:0] op, input logic [31:0] x,
                                input logic [31:0] bv, output logic [63:0] res,
                                output logic er, output logic cy);
    longint unsigned m, xx, bb, s;
    m  = (64'd1 << w) - 64'd1;
    xx = {32'd0, x};
    bb = {32'd0, bv};
    res = '0; er = 1'b0; cy = 1'b0;
    case (op)
      4'd0:  res = '0;
      4'd1:  res = ~xx & m;
      4'd2:  res = xx >> 1;
      4'd3:  res = (xx << 1) & m;
      4'd4:  begin s = xx + bb; res = s & m; cy = ((s >> w) != 0); end
      4'd5:  begin res = (xx - bb) & m; cy = (xx < bb); end
      4'd6:  res = xx * bb;
      4'd7:  if (DIV_EN && bb != 0) res = ((xx % bb) << w) | (xx / bb); else er = 1'b1;
      4'd8:  res = xx & bb;
      4'd9:  res = xx | bb;
      4'd10: res = xx ^ bb;
      4'd11: res = xx;
      default: er = 1'b1;
    endcase
  endfunction

  task automatic drive(input int s, input logic st, input logic [3:0] op, input logic ua,
                       input logic [31:0] av, input logic [31:0] bv);
    if (s == 1) begin
      start8 = st; opc8 = op; ua8 = ua; a8 = av[7:0]; b8 = bv[7:0];
    end else begin
      start16 = st; opc16 = op; ua16 = ua; a16 = av[15:0]; b16 = bv[15:0];
    end
  endtask

  task automatic set_start(input int s, input logic st);
    if (s == 1) start8 = st; else start16 = st;
  endtask

  task automatic do_op(input int s, input logic [3:0] op, input logic ua,
                       input logic [31:0] av, input logic [31:0] bv, input bit dbl);
    int w, lat, k;
    bit got;
    logic [31:0] m, x, bb;
    logic [63:0] eres;
    logic er, cy;
    w  = (s == 1) ? 8 : 16;
    m  = (s == 1) ? 32'hFF : 32'hFFFF;
    x  = ua ? m_acc[s] : (av & m);
    bb = bv & m;
    model(w, op, x, bb, eres, er, cy);
    lat = (DIV_EN && op == 4'd7 && bb != 0) ? w + 2 : 2;
    sel = s;
    @(negedge clock);
    drive(s, 1'b1, op, ua, av, bv);
    @(negedge clock);
    // Scramble inputs after acceptance; a repeated start lands while busy.
    drive(s, dbl, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom, $urandom);
    chk($sformatf("op%0d_busy", op), {63'd0, o_busy}, 64'd1);
    got = 1'b0;
    k = 0;
    for (int i = 2; i <= lat + 4 && !got; i++) begin
      @(posedge clock); #1;
      if (i == 2) set_start(s, 1'b0);
      if (o_done === 1'b1) begin
        got = 1'b1;
        k = i;
      end
    end
    chk($sformatf("op%0d_latency", op), 64'(k), 64'(lat));
    chk($sformatf("op%0d_result", op), o_res, eres);
    chk($sformatf("op%0d_err", op), {63'd0, o_err}, {63'd0, er});
    chk($sformatf("op%0d_zero", op), {63'd0, o_zero}, {63'd0, (eres == 64'd0)});
    chk($sformatf("op%0d_carry", op), {63'd0, o_carry}, {63'd0, cy});
    if (!er) m_acc[s] = eres[31:0] & m;
    chk($sformatf("op%0d_acc", op), {32'd0, o_acc}, {32'd0, m_acc[s]});
    @(posedge clock); #1;
    chk($sformatf("op%0d_done_pulse", op), {63'd0, o_done}, 64'd0);
    chk($sformatf("op%0d_idle", op), {63'd0, o_busy}, 64'd0);
  endtask

  initial begin
    int nd;
    logic [31:0] prev;
    reset = 1'b0;
    drive(0, 1'b0, 4'd0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 4'd0, 1'b0, 32'd0, 32'd0);
    m_acc[0] = '0;
    m_acc[1] = '0;
    repeat (3) @(posedge clock);
    #1;
    sel = 0;
    chk("rst_busy",   {63'd0, o_busy},  64'd0);
    chk("rst_done",   {63'd0, o_done},  64'd0);
    chk("rst_result", o_res,            64'd0);
    chk("rst_acc",    {32'd0, o_acc},   64'd0);
    chk("rst_flags",  {61'd0, o_err, o_zero, o_carry}, 64'd0);
    reset = 1'b1;

    // First start is accepted on the first rising edge after release.
    do_op(0, 4'd11, 1'b0, 32'd3, 32'd0, 1'b0);
    chk("load3_result", o_res, 64'd3);
    do_op(0, 4'd4, 1'b1, 32'd0, 32'hFFFF, 1'b0);
    chk("add_result", o_res, 64'd2);
    chk("add_carry",  {63'd0, o_carry}, 64'd1);
    do_op(0, 4'd5, 1'b1, 32'd0, 32'd5, 1'b0);
    chk("sub_result", o_res, 64'hFFFD);
    chk("sub_borrow", {63'd0, o_carry}, 64'd1);
    do_op(0, 4'd7, 1'b0, 32'd100, 32'd7, 1'b1);
    chk("div_result", o_res, DIV_EN ? 64'h0002000E : 64'd0);
    prev = m_acc[0];
    do_op(0, 4'd7, 1'b0, 32'd100, 32'd0, 1'b0);
    chk("div0_err", {63'd0, o_err}, 64'd1);
    chk("div0_acc", {32'd0, o_acc}, {32'd0, prev});
    do_op(0, 4'd6, 1'b0, 32'hFFFF, 32'hFFFF, 1'b1);
    chk("mul_result", o_res, 64'hFFFE0001);
    chk("mul_acc", {32'd0, o_acc}, 64'd1);
    do_op(0, 4'd13, 1'b0, 32'h55, 32'h66, 1'b0);
    chk("illegal_err", {63'd0, o_err}, 64'd1);
    chk("illegal_zero", {63'd0, o_zero}, 64'd1);
    do_op(0, 4'd0, 1'b0, 32'h1, 32'h1, 1'b0);
    chk("clr_acc", {32'd0, o_acc}, 64'd0);
    do_op(1, 4'd7, 1'b0, 32'd8, 32'd2, 1'b0);
    chk("w8_div_err", {63'd0, o_err}, DIV_EN ? 64'd0 : 64'd1);
    do_op(1, 4'd3, 1'b0, 32'h81, 32'd0, 1'b0);
    chk("w8_shl", o_res, 64'h02);

    for (int n = 0; n < 60; n++) begin
      int s;
      logic [31:0] bv;
      s  = int'($urandom_range(0, 1));
      bv = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      do_op(s, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom, bv,
            ($urandom_range(0, 3) == 0));
    end

    // Abort a long operation with reset in its fifth cycle.
    do_op(0, 4'd11, 1'b0, 32'h1234, 32'd0, 1'b0);
    sel = 0;
    @(negedge clock);
    drive(0, 1'b1, DIV_EN ? 4'd7 : 4'd6, 1'b0, 32'd1000, 32'd3);
    @(negedge clock);
    drive(0, 1'b0, 4'd0, 1'b0, 32'd0, 32'd0);
    repeat (4) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_busy",   {63'd0, o_busy}, 64'd0);
    chk("abort_done",   {63'd0, o_done}, 64'd0);
    chk("abort_result", o_res,           64'd0);
    chk("abort_acc",    {32'd0, o_acc},  64'd0);
    chk("abort_flags",  {61'd0, o_err, o_zero, o_carry}, 64'd0);
    m_acc[0] = '0;
    m_acc[1] = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    nd = 0;
    repeat (22) begin
      @(posedge clock); #1;
      if (o_done === 1'b1) nd++;
    end
    chk("abort_no_done", 64'(nd), 64'd0);
    do_op(0, 4'd11, 1'b0, 32'hBEEF, 32'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_accum_alu.md
SEQ_ACCUM_ALU -- requirements
Module: seq_accum_alu

Interface
REQ-001 SHALL have parameter: WIDTH, 16, operand/accumulator width in bits (legal 4..32).
REQ-002 SHALL have port: clock  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 SHALL have port: start  input  1  operation request, sampled only in IDLE.
REQ-005 SHALL have port: opcode  input  4  operation select.
REQ-006 SHALL have port: use_acc  input  1  1 = first operand X is internal accumulator, 0 = X is a.
REQ-007 SHALL have port: a  input  WIDTH  first operand.
REQ-008 SHALL have port: b  input  WIDTH  second operand.
REQ-009 SHALL have port: busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port: done  output  1  one-cycle pulse, result/flags valid.
REQ-011 SHALL have port: result  output  2*WIDTH  registered result.
REQ-012 SHALL have port: acc  output  WIDTH  accumulator contents.
REQ-013 SHALL have port: err, zero, carry  output  1 each  registered status flags.

Function
REQ-014 SHALL implement opcodes: 0 CLR, 1 NOT X, 2 X>>1 logical, 3 X<<1 logical, 4 X+b, 5 X-b, 6 X*b, 7 X/b, 8 AND, 9 OR, 10 XOR, 11 LOAD (result=X); 12-15 illegal.
REQ-015 SHALL sample opcode, use_acc, a, b only on the edge where start=1 in IDLE; start while busy SHALL be ignored, operands held internally.
REQ-016 SHALL use FSM states IDLE, EXEC, DIV, DONE: IDLE->DIV for legal divide with b!=0, IDLE->EXEC otherwise; EXEC->DONE; DIV->DONE after exactly WIDTH iterations; DONE->IDLE.
REQ-017 SHALL assert done only in DONE (one cycle); latency start-edge to done: 2 cycles for non-divide ops, WIDTH+2 cycles for divide.
REQ-018 SHALL perform divide as restoring shift-subtract, one quotient bit per cycle; result = {remainder, quotient}, each WIDTH bits.
REQ-019 SHALL produce full 2*WIDTH product for MUL; all other ops zero-extend a WIDTH-bit value into result.
REQ-020 ADD/SUB SHALL wrap modulo 2^WIDTH; carry = carry-out for ADD, borrow (X<b) for SUB, 0 for all other ops.
REQ-021 SHALL set err=1 for divide with b=0 (result 0, takes EXEC path), illegal opcode (result 0); err=0 otherwise.
REQ-022 zero SHALL be 1 when result (all 2*WIDTH bits) equals 0.
REQ-023 On done with err=0, acc SHALL load result[WIDTH-1:0]; with err=1 acc SHALL be unchanged; CLR SHALL load 0.
REQ-024 result and flags SHALL hold their values between done pulses; start may be asserted in the cycle after done.

Reset
REQ-025 reset low SHALL immediately force state IDLE, busy=0, done=0, result=0, acc=0, err=0, zero=0, carry=0, including mid-divide (operation aborted, no done).
REQ-026 First start SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-027 With macro SEQ_ACCUM_ALU_DIV_EN defined, SHALL include the iterative divider and DIV state per REQ-016/018.
REQ-028 Without SEQ_ACCUM_ALU_DIV_EN, opcode 7 SHALL behave as illegal: EXEC path, 2-cycle latency, err=1, result 0, acc unchanged; no DIV state logic.

Verification
REQ-029 WIDTH=16: reset, start LOAD a=3 -> done 2 cycles later, result=3, acc=3, err=0.
REQ-030 WIDTH=16: acc=3, use_acc=1, ADD b=16'hFFFF -> result=2, carry=1, acc=2; SUB b=5 from acc=2 -> result=16'hFFFD, carry=1.
REQ-031 WIDTH=16 with DIV_EN: a=100, b=7 DIV -> busy 17 cycles, done at cycle 18, result={16'd2,16'd14}, acc=14; b=0 -> done at cycle 2, err=1, acc unchanged.
REQ-032 WIDTH=16: MUL a=16'hFFFF, b=16'hFFFF -> result=32'hFFFE0001, acc=16'h0001; second start during busy ignored (exactly one done).
REQ-033 Reset asserted mid-divide (cycle 5) -> outputs all 0 asynchronously, no done pulse; opcode 13 -> err=1, result 0, zero=1; CLR -> acc=0, zero=1.
REQ-034 WIDTH=8 without DIV_EN: DIV a=8, b=2 -> done at cycle 2, err=1; SHL a=8'h81 -> result=8'h02.
